// File: rtl/stack_unit_param.sv
// Parametrised operand stack: push/pop/replace/dup/swap, occupancy, sticky errors.
// Define STACK_NOS_OUT_EN to add the next-on-stack read port nos.
module stack_unit_param #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_err,
   output logic [WIDTH-1:0] tos,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
`ifdef STACK_NOS_OUT_EN
   output logic [WIDTH-1:0] nos,
`endif
   output logic             underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_REPL = 3'd3;
   localparam logic [2:0] OP_DUP  = 3'd4;
   localparam logic [2:0] OP_SWAP = 3'd5;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [CW-1:0]    cm1, cm2;
   logic [AW-1:0]    top_idx, nos_idx, push_idx;
   logic             is_empty, is_full, has2;
   logic [WIDTH-1:0] tos_w, nos_w;

   logic             we_a, we_b;
   logic [AW-1:0]    wa_a, wa_b;
   logic [WIDTH-1:0] wd_a, wd_b;
   logic             ovf_evt, unf_evt;

   assign cm1      = count_q - CW'(1);
   assign cm2      = count_q - CW'(2);
   assign top_idx  = cm1[AW-1:0];
   assign nos_idx  = cm2[AW-1:0];
   assign push_idx = count_q[AW-1:0];

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));
   assign has2     = (count_q >= CW'(2));

   // Indices are only meaningful when the guarding occupancy holds.
   assign tos_w = is_empty ? '0 : mem_q[top_idx];
   assign nos_w = has2     ? mem_q[nos_idx] : '0;

   always_comb begin
      count_d = count_q;
      we_a    = 1'b0;
      wa_a    = push_idx;
      wd_a    = din;
      we_b    = 1'b0;
      wa_b    = nos_idx;
      wd_b    = tos_w;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      case (op)
         OP_PUSH: begin
            if (is_full) begin
               ovf_evt = 1'b1;
            end else begin
               we_a    = 1'b1;
               count_d = count_q + CW'(1);
            end
         end
         OP_POP: begin
            if (is_empty) unf_evt = 1'b1;
            else          count_d = cm1;
         end
         OP_REPL: begin
            if (is_empty) begin
               unf_evt = 1'b1;
            end else begin
               we_a = 1'b1;
               wa_a = top_idx;
            end
         end
         OP_DUP: begin
            if (is_empty) begin
               unf_evt = 1'b1;
            end else if (is_full) begin
               ovf_evt = 1'b1;
            end else begin
               we_a    = 1'b1;
               wd_a    = tos_w;
               count_d = count_q + CW'(1);
            end
         end
         OP_SWAP: begin
            if (!has2) begin
               unf_evt = 1'b1;
            end else begin
               we_a = 1'b1;
               wa_a = top_idx;
               wd_a = nos_w;
               we_b = 1'b1;
            end
         end
         default: ;
      endcase
      // A fresh error outranks the clear request.
      ovf_d = (ovf_q & ~clr_err) | ovf_evt;
      unf_d = (unf_q & ~clr_err) | unf_evt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && we_a) mem_q[wa_a] <= wd_a;
      if (rst && we_b) mem_q[wa_b] <= wd_b;
   end

   assign tos       = tos_w;
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
`ifdef STACK_NOS_OUT_EN
   assign nos       = nos_w;
`endif

endmodule

// File: doc/stack_unit_param.md
Name: stack_unit_param

Overview:
- Parametrised operand stack for the next-generation stack multicycle processor. Replaces the fixed push/pop/tos storage in the datapath.
- Adds configurable depth and width, an encoded op port (replace, dup, swap), occupancy count, and sticky overflow/underflow flags.
- Driven by the control unit one op per cycle. TOS feeds the ALU operand registers and the memory write-data mux.

Parameters:
- WIDTH, 8, data width of each stack entry in bits (>=1).
- DEPTH, 8, number of entries (>=2).
- CW, $clog2(DEPTH+1), width of count output (derived, do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 REPL, 4 DUP, 5 SWAP, 6/7 reserved (act as NOP).
- din  in  WIDTH  data for PUSH/REPL.
- clr_err  in  1  synchronous clear of sticky error flags.
- tos  out  WIDTH  top-of-stack entry; 0 when empty.
- count  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: an op was rejected for lack of space.
- underflow  out  1  sticky: an op was rejected for lack of operands.

Behaviour:
- Reset (rst low, async): count=0, overflow=0, underflow=0. Storage contents do not matter. Outputs read tos=0, empty=1, full=0. No op takes effect while rst is low. Release is synchronous to the next clk edge.
- Storage is a register array indexed by count. tos is a combinational read of entry[count-1], forced to 0 when empty.
- All state updates occur on the rising clk edge. Results are visible on tos/count/empty/full immediately after that edge (1-cycle latency).
- PUSH: if !full, entry[count]=din and count+1. If full, no change and overflow=1.
- POP: if !empty, count-1; the entry is not cleared. If empty, no change and underflow=1.
- REPL (pop and push in one cycle; used for ALU result write-back): if !empty, entry[count-1]=din and count unchanged. If empty, no change and underflow=1.
- DUP: needs count>=1 and !full. Then entry[count]=entry[count-1] and count+1. If empty: underflow=1, no change. If full and non-empty: overflow=1, no change.
- SWAP: needs count>=2. Exchanges entry[count-1] and entry[count-2]; count unchanged. If count<2: underflow=1, no change.
- NOP/reserved: no change.
- Error flags are sticky. clr_err=1 clears both on the next edge. If clr_err and a new error occur in the same cycle, the new error wins (flag reads 1 afterwards) and the other flag clears.
- A rejected op never corrupts storage or count.
- count never exceeds DEPTH and never wraps below 0.
- Reset asserted mid-sequence returns to the empty state immediately. The first op after release behaves as on an empty stack.

Optional Feature:
- Macro STACK_NOS_OUT_EN.
- Defined: adds output port nos (out, WIDTH), a combinational read of entry[count-2], 0 when count<2. This lets the control unit fetch both binary-op operands in one state.
- Not defined: port nos is absent. Operands are obtained by POP then read tos.
- All other behaviour is identical in both builds.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then PUSH 0x11,0x22,0x33 -> tos=0x33, count=3, empty=0, full=0, no flags.
- From that state: SWAP -> tos=0x22; POP -> tos=0x33, count=2; REPL din=0x5A -> tos=0x5A, count=2.
- PUSH until count=4 (full=1), then PUSH 0x99 -> overflow=1, count=4, tos unchanged. DUP -> still overflow, no change. clr_err -> overflow=0.
- From empty: POP, REPL, DUP -> underflow=1 each, count=0, tos=0. PUSH 0x07 then SWAP -> underflow stays 1, tos=0x07.
- Cycle with underflow=1, clr_err=1 and PUSH while full -> overflow=1, underflow=0 afterwards.
- Assert rst low asynchronously between edges with count=3 -> count=0, empty=1, tos=0, flags 0 immediately. With STACK_NOS_OUT_EN after PUSH 0xA1,0xB2: nos=0xA1, tos=0xB2.
